// File: rtl/ones_pkg.sv
// ones_pkg: shared widths and state encoding for the ones-counting datapath.
//   OC_WIDTH    frame length in bits
//   OC_CW       count width, $clog2(OC_WIDTH+1)
//   ofg_state_t frame generator states (IDLE, SEND)
package ones_pkg;
    localparam int OC_WIDTH = 15;
    localparam int OC_CW = $clog2(OC_WIDTH + 1);
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} ofg_state_t;
endpackage

// File: rtl/therm_decode.sv
// therm_decode: combinational count -> thermometer word, clamping counts above WIDTH.
//   count  in  [CW-1:0]    requested number of ones
//   n      out [CW-1:0]    count clamped to WIDTH
//   therm  out [WIDTH-1:0] n LSBs set
module therm_decode import ones_pkg::*; #(
    parameter int WIDTH = OC_WIDTH,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic [CW-1:0]    count,
    output logic [CW-1:0]    n,
    output logic [WIDTH-1:0] therm
);
    localparam logic [CW-1:0] MAX = CW'(WIDTH);
    assign n = (count > MAX) ? MAX : count;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign therm[i] = (n > CW'(i));
    end
endmodule

// File: rtl/ones_frame_gen.sv
// ones_frame_gen: serial unary encoder, emits WIDTH-bit frames of N leading ones.
//   clk, rst_n   clock, async active-low reset
//   count_in     ones count for the next frame, sampled on accept
//   in_valid     count_in is valid
//   in_ready     combinational: idle, or on the last bit of a frame
//   ser_out      registered serial frame bit
//   frame_start  registered, high with bit 0
//   frame_end    registered, high with bit WIDTH-1
//   busy         a frame bit is on ser_out
//   therm_out    thermometer word of the last accepted count
module ones_frame_gen import ones_pkg::*; #(
    parameter int WIDTH = OC_WIDTH,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW-1:0]    count_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy,
    output logic [WIDTH-1:0] therm_out
);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    ofg_state_t       state_q, state_d;
    logic [CW-1:0]    bit_idx_q, bit_idx_d, cnt_q, cnt_d, n;
    logic [WIDTH-1:0] therm_q, therm_d, therm_n;
    logic             ser_out_q, ser_out_d, frame_start_q, frame_start_d, frame_end_q, frame_end_d;
    logic             last, accept;

    therm_decode #(.WIDTH(WIDTH)) u_dec (
        .count(count_in),
        .n    (n),
        .therm(therm_n)
    );

    assign last     = (state_q == SEND) && (bit_idx_q == LAST);
    assign in_ready = rst_n && ((state_q == IDLE) || last);
    assign accept   = in_valid && in_ready;

    // Serial outputs are computed from the next-cycle state so the registered
    // bits line up with the bit index they describe.
    always_comb begin
        state_d       = accept ? SEND : (last ? IDLE : state_q);
        bit_idx_d     = (state_q == SEND && !last) ? bit_idx_q + 1'b1 : '0;
        cnt_d         = accept ? n : cnt_q;
        therm_d       = accept ? therm_n : therm_q;
        ser_out_d     = (state_d == SEND) && (bit_idx_d < cnt_d);
        frame_start_d = (state_d == SEND) && (bit_idx_d == '0);
        frame_end_d   = (state_d == SEND) && (bit_idx_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bit_idx_q     <= '0;
            cnt_q         <= '0;
            therm_q       <= '0;
            ser_out_q     <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            cnt_q         <= cnt_d;
            therm_q       <= therm_d;
            ser_out_q     <= ser_out_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign ser_out     = ser_out_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign busy        = (state_q == SEND);
    assign therm_out   = therm_q;
endmodule

// File: tb/tb_ones_frame_gen.sv
// tb_ones_frame_gen: scoreboard bench for ones_frame_gen; driver queues expected frame bits, monitor pops on busy.
module tb_ones_frame_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  count_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, ser_out, frame_start, frame_end, busy;
    logic [14:0] therm_out;
    logic [3:0]  ref_cnt = '0;
    logic [3:0]  ref_n;
    logic [14:0] ref_therm;

    typedef struct {
        logic        ser;
        logic        fs;
        logic        fe;
        logic [14:0] therm;
        int          n;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   run = 0;
    int   max_run = 0;
    int   ones = 0;
    logic fe_acc;

    always #5 clk = ~clk;

    ones_frame_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .count_in   (count_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_out    (ser_out),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .busy       (busy),
        .therm_out  (therm_out)
    );

    therm_decode #(.WIDTH(15)) u_ref (
        .count(ref_cnt),
        .n    (ref_n),
        .therm(ref_therm)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic send(input logic [3:0] c, output logic fe_at_acc);
        int   w = 0;
        exp_t e;
        count_in = c;
        in_valid = 1'b1;
        while (!in_ready && w < 40) begin
            @(negedge clk);
            w++;
        end
        fe_at_acc = frame_end;
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < 15; i++) begin
            e.ser   = (i < int'(c));
            e.fs    = (i == 0);
            e.fe    = (i == 14);
            e.therm = 15'((32'd1 << c) - 32'd1);
            e.n     = int'(c);
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                run++;
                if (run > max_run) max_run = run;
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (frame_start) ones = 0;
                    if (ser_out) ones++;
                    chk("ser_out", 32'(ser_out), 32'(e.ser));
                    chk("frame_start", 32'(frame_start), 32'(e.fs));
                    chk("frame_end", 32'(frame_end), 32'(e.fe));
                    chk("therm_out", 32'(therm_out), 32'(e.therm));
                    if (e.fe) chk("round_trip", 32'(ones), 32'(e.n));
                end
            end else begin
                run = 0;
                chk("idle_quiet", {29'd0, ser_out, frame_start, frame_end}, 32'd0);
            end
        end
    end

    initial begin
        // Reference decoder sanity during reset
        for (int c = 0; c < 16; c++) begin
            ref_cnt = 4'(c);
            #1;
            chk("ref_therm", 32'(ref_therm), (32'd1 << c) - 32'd1);
        end
        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_outs", {28'd0, ser_out, frame_start, frame_end, busy}, 32'd0);
        chk("rst_therm", 32'(therm_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(in_ready), 32'd1);

        // Count 5, single request with explicit frame timing
        send(4'd5, fe_acc);
        chk("c5_bit0_busy", {30'd0, busy, frame_start}, 32'd3);
        chk("c5_therm", 32'(therm_out), 32'h001F);
        repeat (14) @(negedge clk);
        chk("c5_frame_end", {30'd0, frame_end, in_ready}, 32'd3);
        @(negedge clk);
        chk("c5_idle", {30'd0, busy, in_ready}, 32'd1);

        // Boundary counts
        send(4'd0, fe_acc);
        repeat (15) @(negedge clk);
        send(4'd15, fe_acc);
        chk("c15_therm", 32'(therm_out), 32'h7FFF);
        repeat (15) @(negedge clk);

        // Back-to-back: 3 then 12, second accept on frame_end
        max_run = 0;
        send(4'd3, fe_acc);
        send(4'd12, fe_acc);
        chk("b2b_accept_on_fe", 32'(fe_acc), 32'd1);
        repeat (16) @(negedge clk);
        chk("b2b_busy_run", 32'(max_run), 32'd30);

        // Backpressure: 9 offered mid-frame, replaced by 2 before frame_end
        send(4'd4, fe_acc);
        count_in = 4'd9;
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        send(4'd2, fe_acc);
        chk("bp_accept_on_fe", 32'(fe_acc), 32'd1);
        repeat (16) @(negedge clk);

        // Reset mid-frame at bit 7 of a count-10 frame
        send(4'd10, fe_acc);
        repeat (7) @(negedge clk);
        chk("pre_rst_ser", 32'(ser_out), 32'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_rst_outs", {28'd0, ser_out, frame_start, frame_end, busy}, 32'd0);
        chk("async_rst_ready", 32'(in_ready), 32'd0);
        chk("async_rst_therm", 32'(therm_out), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", {30'd0, busy, in_ready}, 32'd1);
        repeat (20) @(negedge clk);

        // Round-trip over every count, back-to-back
        for (int c = 0; c < 16; c++) send(4'(c), fe_acc);
        repeat (20) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("final_idle", {30'd0, busy, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
